// File: rtl/dd_pkg.sv
// Shared definitions for the sequential double-dabble converter.
// Contents: FSM state encoding, add-3 correction constant, correction
// threshold, and a constant power-of-ten helper for parameter checks.
package dd_pkg;

  typedef enum logic [1:0] {
    DD_IDLE  = 2'd0,
    DD_ADJ   = 2'd1,
    DD_SHIFT = 2'd2,
    DD_DONE  = 2'd3
  } dd_state_t;

  localparam logic [3:0] DD_ADD3   = 4'd3;
  localparam logic [3:0] DD_THRESH = 4'd5;

  // 10**n, evaluated at elaboration to confirm the BCD field is wide enough.
  function automatic longint dd_pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder.
// Ports: a, b (4-bit operands), cin (carry in), sum (4-bit), cout (carry out).
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/dd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble). One shared rca4 adds 3
// to one digit per cycle; after every digit has been visited the whole
// {bcd, binary} register shifts left by one bit.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   conversion request, sampled only in IDLE
//   bin_in  binary operand, captured on the accepting edge
//   busy    high during ADJ and SHIFT
//   done    one-cycle pulse when bcd_out is updated
//   bcd_out packed BCD result, digit 0 in [3:0], held until the next done
module dd_seq_ctrl
  import dd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4,
  parameter int IDX_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SREG_W = BCD_W + BIN_W;

  if (dd_pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_bad_digits
    $error("dd_seq_ctrl: DIGITS too small to hold 2**BIN_W-1");
  end
  if (BIN_W > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
    $error("dd_seq_ctrl: CNT_W cannot hold BIN_W");
  end
  if (DIGITS - 1 > (2 ** IDX_W) - 1) begin : g_bad_idx_w
    $error("dd_seq_ctrl: IDX_W cannot hold DIGITS-1");
  end

  dd_state_t          state, state_nxt;
  logic [SREG_W-1:0]  sreg;
  logic [SREG_W-1:0]  sreg_shl;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   dig_idx;
  logic [IDX_W+1:0]   dig_ofs;
  logic [3:0]         sel_dig;
  logic [3:0]         add_sum;
  logic               unused_cout;
  logic               last_dig;
  logic               last_bit;

  assign dig_ofs  = {dig_idx, 2'b00};
  assign sel_dig  = sreg[BIN_W + int'(dig_ofs) +: 4];
  assign sreg_shl = {sreg[SREG_W-2:0], 1'b0};
  assign last_dig = (dig_idx == IDX_W'(DIGITS - 1));
  assign last_bit = (bit_cnt == CNT_W'(1));

  // Digit is at most 9, so the sum never exceeds 12 and the carry is dead.
  rca4 u_add3 (
    .a    (sel_dig),
    .b    (DD_ADD3),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      DD_IDLE:  if (start) state_nxt = DD_ADJ;
      DD_ADJ: begin
        busy = 1'b1;
        if (last_dig) state_nxt = DD_SHIFT;
      end
      DD_SHIFT: begin
        busy      = 1'b1;
        state_nxt = last_bit ? DD_DONE : DD_ADJ;
      end
      DD_DONE:  state_nxt = DD_IDLE;
      default:  state_nxt = DD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      dig_idx <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DD_IDLE: begin
          if (start) begin
            sreg    <= {{BCD_W{1'b0}}, bin_in};
            bit_cnt <= CNT_W'(BIN_W);
            dig_idx <= '0;
          end
        end
        DD_ADJ: begin
          if (sel_dig >= DD_THRESH) sreg[BIN_W + int'(dig_ofs) +: 4] <= add_sum;
          dig_idx <= last_dig ? '0 : dig_idx + IDX_W'(1);
        end
        DD_SHIFT: begin
          sreg    <= sreg_shl;
          bit_cnt <= bit_cnt - CNT_W'(1);
          // Final shift: publish the BCD field of the shifted value.
          if (last_bit) begin
            bcd_out <= sreg_shl[SREG_W-1 -: BCD_W];
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dd_seq_ctrl.sv
// Self-checking bench for dd_seq_ctrl: directed cases plus all 256 inputs in
// random order with random start/bin_in noise during conversions, checked
// against a decimal-arithmetic reference.
module tb_dd_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int n_chk;
  int n_fail;
  int cyc_g;
  int done_cnt;
  int last_done_cyc;

  dd_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_g <= cyc_g + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic [11:0] bcd_ref(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; returns just after the falling edge
  // following the DONE cycle (the first IDLE cycle).
  task automatic run_conv(input logic [7:0] v, input bit noise);
    int cyc;
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      if (noise && cyc < 30) begin
        start  = 1'($urandom);
        bin_in = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("latency_%0d", v), 32'(cyc), 32'd33);
    check($sformatf("bcd_%0d", v), 32'(bcd_out), 32'(bcd_ref(v)));
    last_done_cyc = cyc_g;
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  int vals[6] = '{0, 9, 10, 99, 128, 200};
  int perm[256];
  int t1, d0, cyc;

  initial begin
    n_chk = 0; n_fail = 0; cyc_g = 0; done_cnt = 0; last_done_cyc = 0;
    rst_n = 1'b0; start = 1'b0; bin_in = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h000);

    // Max value, then the directed sweep
    run_conv(8'd255, 1'b0);
    foreach (vals[i]) run_conv(8'(vals[i]), 1'b0);

    // start held and bin_in changed mid-conversion; start during DONE
    d0     = done_cnt;
    start  = 1'b1;
    bin_in = 8'd42;
    @(negedge clk);
    bin_in = 8'd7;
    cyc    = 1;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc >= 25) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("hold_latency", 32'(cyc), 32'd33);
    check("hold_bcd", 32'(bcd_out), 32'h042);
    start  = 1'b1;
    bin_in = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("done_cycle_start_busy", 32'(busy), 32'd0);
    check("done_cycle_start_bcd", 32'(bcd_out), 32'h042);
    check("hold_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset at cycle 15 of a conversion
    start  = 1'b1;
    bin_in = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'h000);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_conv(8'd100, 1'b0);

    // Back-to-back
    run_conv(8'd17, 1'b0);
    t1 = last_done_cyc;
    run_conv(8'd64, 1'b0);
    check("b2b_spacing", 32'(last_done_cyc - t1), 32'd34);

    // All 256 inputs, shuffled, with input noise while busy
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, tmp;
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      run_conv(8'(perm[i]), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dd_seq_ctrl.md
Name: dd_seq_ctrl

Overview:
Sequential binary-to-BCD converter (double dabble) that time-shares one 4-bit ripple-carry adder across all BCD digits.
- A small FSM visits one digit per cycle, applies the add-3 correction through the shared adder when the digit is 5 or more, then shifts the whole register left by one bit.
- Sits between binary datapath results and BCD display/reporting logic.

Parameters:
BIN_W, 8, width of binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; a violation is an elaboration error.
CNT_W, 4, width of the bit counter. Must hold BIN_W.
IDX_W, 2, width of the digit index. Must hold DIGITS-1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request a conversion; sampled only in IDLE
bin_in  input  BIN_W  binary operand; captured on the accepting edge
busy  output  1  high while the conversion is in ADJ or SHIFT
done  output  1  one-cycle pulse; result is valid
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds until the next done

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n low at a rising edge).
- Reset state: FSM=IDLE, busy=0, done=0, bcd_out=0, internal registers=0.
- Reset mid-conversion: the next edge aborts to IDLE. The partial result is discarded and done is never pulsed.
- Internal register: sreg[4*DIGITS+BIN_W-1:0] = {bcd field, binary field}.
- Counters: bit_cnt (CNT_W bits), dig_idx (IDX_W bits).
- Shared adder: a = selected digit (sreg nibble dig_idx of the bcd field), b=4'd3, cin=0. cout is ignored; digit max 9 gives sum max 12, so no overflow.
- FSM states: IDLE, ADJ, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: sreg <= {0, bin_in}; bit_cnt <= BIN_W; dig_idx <= 0; next state ADJ.
  - start=0: stay in IDLE.
- ADJ:
  - If the selected digit >= 5, that nibble <= adder sum; otherwise unchanged.
  - If dig_idx == DIGITS-1: dig_idx <= 0; next state SHIFT. Otherwise dig_idx++ and stay in ADJ.
  - Exactly one nibble is modified per cycle.
- SHIFT:
  - sreg <= sreg << 1; bit_cnt--.
  - If bit_cnt was 1: bcd_out <= bcd field of the shifted value; done <= 1; next state DONE.
  - Otherwise next state ADJ.
- DONE: done=1 for this single cycle; next state IDLE; done returns to 0.
- busy=1 in ADJ and SHIFT; 0 in IDLE and DONE.
- Latency: done is high BIN_W*(DIGITS+1)+1 edges after the accepting edge, counting the accepting edge as edge 1. With defaults this is edge 33; the conversion occupies 32 ADJ/SHIFT cycles.
- Throughput: next start is accepted in the first IDLE cycle after DONE. Minimum start-to-start spacing is BIN_W*(DIGITS+1)+2 cycles (34 with defaults).
- start during ADJ, SHIFT or DONE is ignored, not queued. bin_in changes after the accepting edge do not affect the result.
- Standard double dabble: the correction pass precedes every shift, including the first, where it has no effect because the field is zero. No correction follows the final shift.
- bcd_out changes only at the SHIFT->DONE edge and on reset.

Decomposition:
- Shared package/header dd_pkg:
  - state encodings DD_IDLE=2'd0, DD_ADJ=2'd1, DD_SHIFT=2'd2, DD_DONE=2'd3
  - constant DD_ADD3=4'd3
  - constant DD_THRESH=4'd5
- One sub-module instance: the team's existing 4-bit ripple-carry adder rca4, as the single shared add-3 resource.
- FSM, counters and shift register live in dd_seq_ctrl.

Test Plan:
- Reset: rst_n=0 for 2 edges, then 1 -> busy=0, done=0, bcd_out=12'h000.
- Max value: start with bin_in=8'd255 -> busy=1 from the next cycle; done pulses exactly 1 cycle at edge 33; bcd_out=12'h255.
- Value sweep: bin_in=0, 8'd9, 8'd10, 8'd99, 8'd128, 8'd200, each after the previous done -> bcd_out = 12'h000, 009, 010, 099, 128, 200 respectively. Cross-check all 256 inputs against a reference model.
- start held high and bin_in changed to 8'd7 during a conversion of 8'd42 -> single done with bcd_out=12'h042.
- start high in the DONE cycle -> 8'd7 is not accepted.
- rst_n low for 1 edge at cycle 15 of a conversion of 8'd255 -> IDLE, bcd_out=12'h000, no done. A fresh start with 8'd100 then gives bcd_out=12'h100 at edge 33.
- Back-to-back: start asserted on the first IDLE cycle after done, for 8'd17 then 8'd64 -> two done pulses 34 cycles apart; bcd_out 12'h017 then 12'h064.
